// File: rtl/mem_arbiter_if.sv
// Bus bundle between the I-cache, D-cache and physical memory for mem_arbiter.
// Handshake: a cache holds *_read/*_write (plus address/data) at level until its
// *_resp pulses for one cycle; the arbiter holds pmem_* stable until pmem_resp.
interface mem_arbiter_if;
  logic         i_read;
  logic [31:0]  i_addr;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_addr;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_addr;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client (I-cache / D-cache) arbiter onto a single line-wide physical memory.
// Define MEM_ARB_RR_EN for round-robin priority; otherwise D always beats I.
module mem_arbiter (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic         wr_q, wr_d;
  logic [31:0]  addr_q, addr_d;
  logic [255:0] wdata_q, wdata_d;
  logic         d_req;
  logic         d_wins;

`ifdef MEM_ARB_RR_EN
  // 1 when D was the most recent grant; reset leaves I as last winner.
  logic         last_q, last_d;
`endif

  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef MEM_ARB_RR_EN
    last_d  = last_q;
`endif

    d_req = bus.d_read | bus.d_write;
`ifdef MEM_ARB_RR_EN
    d_wins = d_req & (~bus.i_read | ~last_q);
`else
    d_wins = d_req;
`endif

    bus.i_rdata    = '0;
    bus.i_resp     = 1'b0;
    bus.d_rdata    = '0;
    bus.d_resp     = 1'b0;
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    bus.pmem_addr  = '0;
    bus.pmem_wdata = '0;

    case (state_q)
      IDLE: begin
        if (d_wins) begin
          state_d = SERVE_D;
          // Read+write together is a writeback; the read is retried afterwards.
          wr_d    = bus.d_write;
          addr_d  = bus.d_addr;
          wdata_d = bus.d_write ? bus.d_wdata : '0;
`ifdef MEM_ARB_RR_EN
          last_d  = 1'b1;
`endif
        end else if (bus.i_read) begin
          state_d = SERVE_I;
          wr_d    = 1'b0;
          addr_d  = bus.i_addr;
          wdata_d = '0;
`ifdef MEM_ARB_RR_EN
          last_d  = 1'b0;
`endif
        end
      end
      SERVE_I: begin
        bus.pmem_read = 1'b1;
        bus.pmem_addr = addr_q;
        if (bus.pmem_resp) begin
          bus.i_rdata = bus.pmem_rdata;
          bus.i_resp  = 1'b1;
          state_d     = DONE;
        end
      end
      SERVE_D: begin
        bus.pmem_read  = ~wr_q;
        bus.pmem_write = wr_q;
        bus.pmem_addr  = addr_q;
        bus.pmem_wdata = wdata_q;
        if (bus.pmem_resp) begin
          bus.d_rdata = bus.pmem_rdata;
          bus.d_resp  = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        // Quiet cycle lets the finished requester drop its request first.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level reference model checked
// every cycle, plus literal expectations for the headline scenarios.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model: one outstanding transaction at a time, one quiet cycle after.
  bit           m_busy, m_gap, m_src_d, m_wr, m_last_d;
  logic [31:0]  m_addr;
  logic [255:0] m_wdata;

  // Observations of DUT behaviour for the literal checks.
  int           rd_cyc, wr_cyc, ir_cnt, dr_cnt;
  logic [255:0] last_ir, last_dr, last_wd;
  logic [31:0]  last_addr;
  bit           obs_q[$];

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_update();
    bit dreq, pick_d;
    if (!rst) begin
      m_busy = 1'b0; m_gap = 1'b0; m_last_d = 1'b0;
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (m_busy) begin
      if (bus.pmem_resp) begin
        m_busy = 1'b0; m_gap = 1'b1;
      end
    end else if (bus.i_read || bus.d_read || bus.d_write) begin
      dreq = bus.d_read || bus.d_write;
`ifdef MEM_ARB_RR_EN
      pick_d = dreq && (!bus.i_read || !m_last_d);
`else
      pick_d = dreq;
`endif
      m_busy   = 1'b1;
      m_src_d  = pick_d;
      m_last_d = pick_d;
      if (pick_d) begin
        m_wr    = bus.d_write;
        m_addr  = bus.d_addr;
        m_wdata = bus.d_write ? bus.d_wdata : '0;
      end else begin
        m_wr    = 1'b0;
        m_addr  = bus.i_addr;
        m_wdata = '0;
      end
    end
  endtask

  task automatic compare();
    bit hit;
    hit = m_busy && (bus.pmem_resp === 1'b1);
    chk("pmem_cmd", {bus.pmem_read, bus.pmem_write, bus.pmem_addr, bus.pmem_wdata},
        {m_busy && !m_wr, m_busy && m_wr, m_busy ? m_addr : 32'd0, m_busy ? m_wdata : 256'd0});
    chk("icache_ret", {bus.i_resp, bus.i_rdata},
        {hit && !m_src_d, (hit && !m_src_d) ? bus.pmem_rdata : 256'd0});
    chk("dcache_ret", {bus.d_resp, bus.d_rdata},
        {hit && m_src_d, (hit && m_src_d) ? bus.pmem_rdata : 256'd0});
  endtask

  // One clock: compare at negedge, advance model at posedge, return just after.
  task automatic tick();
    @(negedge clk);
    if (chk_en) begin
      compare();
      if (bus.pmem_read) rd_cyc++;
      if (bus.pmem_write) begin wr_cyc++; last_wd = bus.pmem_wdata; end
      if (bus.i_resp) begin ir_cnt++; last_ir = bus.i_rdata; obs_q.push_back(1'b0); end
      if (bus.d_resp) begin
        dr_cnt++; last_dr = bus.d_rdata; last_addr = bus.pmem_addr; obs_q.push_back(1'b1);
      end
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    chk_en = 1'b1;
  endtask

  task automatic wait_cmd();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (bus.pmem_read || bus.pmem_write) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_fail++;
      $display("FAIL wait_cmd: no pmem command within 50 cycles, required one");
    end
  endtask

  task automatic respond(input int lat, input logic [255:0] data);
    for (int k = 1; k < lat; k++) tick();
    bus.pmem_rdata = data;
    bus.pmem_resp  = 1'b1;
    tick();
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
  endtask

  initial begin
    int b_rd, b_wr, b_ir, b_dr, b_obs;
    bit exp_order[3];
    logic [255:0] tdata;

    rst = 1'b0;
    bus.i_read = 1'b0; bus.i_addr = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;
    rd_cyc = 0; wr_cyc = 0; ir_cnt = 0; dr_cnt = 0;
    last_ir = '0; last_dr = '0; last_wd = '0; last_addr = '0;

    // Reset state.
    do_reset();
    chk("reset_cmds", {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp}, 4'b0000);
    chk("reset_addr", bus.pmem_addr, 32'd0);
    chk("reset_idle", dbg_state, 2'd0);

    // I-cache read, memory answers on the fifth command cycle.
    b_rd = rd_cyc; b_ir = ir_cnt;
    bus.i_read = 1'b1; bus.i_addr = 32'h0000_1000;
    wait_cmd();
    bus.i_read = 1'b0;
    respond(5, {32{8'hAA}});
    tick();
    tick();
    chk("i_read_cycles", rd_cyc - b_rd, 5);
    chk("i_resp_pulses", ir_cnt - b_ir, 1);
    chk("i_rdata_val", last_ir, {32{8'hAA}});
    chk("i_back_idle", dbg_state, 2'd0);

    // D-cache writeback.
    b_rd = rd_cyc; b_wr = wr_cyc; b_dr = dr_cnt;
    bus.d_write = 1'b1; bus.d_addr = 32'h0000_2040; bus.d_wdata = {32{8'h55}};
    wait_cmd();
    bus.d_write = 1'b0;
    respond(3, '0);
    tick();
    tick();
    chk("d_write_cycles", wr_cyc - b_wr, 3);
    chk("d_write_no_read", rd_cyc - b_rd, 0);
    chk("d_resp_pulses", dr_cnt - b_dr, 1);
    chk("d_wdata_val", last_wd, {32{8'h55}});

    // Simultaneous requests held across three back-to-back grants.
    do_reset();
    b_obs = obs_q.size();
    bus.i_read = 1'b1; bus.i_addr = 32'h0000_5000;
    bus.d_read = 1'b1; bus.d_addr = 32'h0000_6000;
    for (int t = 0; t < 3; t++) begin
      wait_cmd();
      tdata = {224'd0, 32'hC0DE_0000 + t};
      respond(2, tdata);
    end
    bus.i_read = 1'b0; bus.d_read = 1'b0;
    tick();
    tick();
`ifdef MEM_ARB_RR_EN
    exp_order[0] = 1'b1; exp_order[1] = 1'b0; exp_order[2] = 1'b1;
`else
    exp_order[0] = 1'b1; exp_order[1] = 1'b1; exp_order[2] = 1'b1;
`endif
    chk("grant_count", obs_q.size() - b_obs, 3);
    for (int t = 0; t < 3; t++) begin
      chk($sformatf("grant_order_%0d(1=D)", t),
          (obs_q.size() > b_obs + t) ? obs_q[b_obs + t] : 1'bx, exp_order[t]);
    end

    // Requester drops d_read one cycle into service; transfer must still finish.
    b_dr = dr_cnt;
    bus.d_read = 1'b1; bus.d_addr = 32'h0000_3000;
    wait_cmd();
    tick();
    bus.d_read = 1'b0;
    respond(4, {8{32'h1234_5678}});
    tick();
    tick();
    chk("drop_d_resp", dr_cnt - b_dr, 1);
    chk("drop_addr", last_addr, 32'h0000_3000);
    chk("drop_rdata", last_dr, {8{32'h1234_5678}});

    // Reset two cycles into an I transfer, stale pmem_resp right after.
    b_ir = ir_cnt;
    bus.i_read = 1'b1; bus.i_addr = 32'h0000_4000;
    wait_cmd();
    bus.i_read = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    bus.pmem_resp = 1'b1; bus.pmem_rdata = {32{8'hFF}};
    chk("abort_pmem_read", bus.pmem_read, 1'b0);
    chk("abort_idle", dbg_state, 2'd0);
    tick();
    bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;
    tick();
    chk("abort_no_i_resp", ir_cnt - b_ir, 0);

    // Stray pmem_resp while idle.
    b_ir = ir_cnt; b_dr = dr_cnt;
    bus.pmem_resp = 1'b1; bus.pmem_rdata = {8{32'hDEAD_BEEF}};
    tick();
    bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;
    tick();
    chk("stray_no_resp", (ir_cnt - b_ir) + (dr_cnt - b_dr), 0);
    chk("stray_idle", dbg_state, 2'd0);
    chk("stray_no_cmd", {bus.pmem_read, bus.pmem_write}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous and active-low.
REQ-003 i_read  input  1  instruction-cache line read request.
REQ-004 i_addr  input  32  instruction line address, rv32i_word.
REQ-005 i_rdata  output  256  line returned to instruction cache.
REQ-006 i_resp  output  1  one-cycle completion pulse to instruction cache.
REQ-007 d_read / d_write  input  1 each  data-cache line read/writeback request.
REQ-008 d_addr  input  32  data line address, rv32i_word.
REQ-009 d_wdata  input  256  writeback line.
REQ-010 d_rdata  output  256  line returned to data cache.
REQ-011 d_resp  output  1  one-cycle completion pulse to data cache.
REQ-012 pmem_read / pmem_write  output  1 each  physical memory commands.
REQ-013 pmem_addr  output  32  physical memory address.
REQ-014 pmem_wdata  output  256  physical memory write line.
REQ-015 pmem_rdata  input  256  physical memory read line.
REQ-016 pmem_resp  input  1  physical memory completion pulse.

Function
REQ-017 The FSM SHALL have states IDLE, SERVE_I, SERVE_D, DONE.
REQ-018 In IDLE with a pending request, the FSM SHALL grant on the next edge: the request source, address, direction and write data are latched into internal registers.
REQ-019 Grant priority SHALL be set by REQ-031/REQ-032.
REQ-020 In SERVE_I and SERVE_D, pmem_read/pmem_write, pmem_addr and pmem_wdata SHALL be driven only from the latched registers and SHALL stay stable until pmem_resp.
REQ-021 A D-grant with d_read and d_write both high SHALL be serviced as a write only: pmem_write=1, pmem_read=0.
REQ-022 Read data routing on pmem_resp:
  - pmem_rdata SHALL pass combinationally to i_rdata (SERVE_I) or d_rdata (SERVE_D).
  - The matching *_resp SHALL pulse in the same cycle.
  - The FSM SHALL then enter DONE.
REQ-023 DONE SHALL last exactly one cycle with all pmem commands low, then go to IDLE, so a requester can drop its request before re-arbitration.
REQ-024 Request handling during service:
  - Once granted, a transfer SHALL complete even if the requester drops its request.
  - Requests arriving during service SHALL wait; none SHALL be lost.
REQ-025 Latency from grant edge to pmem command SHALL be 0 cycles; minimum request-to-resp is 2 cycles plus memory latency.
REQ-026 At most one of i_resp/d_resp SHALL be high in any cycle; at most one of pmem_read/pmem_write SHALL be high in any cycle.
REQ-027 pmem_resp in IDLE or DONE SHALL be ignored.
REQ-028 i_rdata/d_rdata SHALL be 0 outside their respective resp cycle.

Reset
REQ-029 When rst=0 at a clock edge:
  - the FSM SHALL go to IDLE;
  - latched registers and the last-grant flag SHALL clear to 0 (last grant = I);
  - all outputs SHALL be 0 from the following cycle.
REQ-030 Reset mid-transfer SHALL abort it with no resp pulse; a pmem_resp in the first post-reset cycle SHALL be ignored.

Configuration
REQ-031 With macro MEM_ARB_RR_EN defined, priority SHALL be round-robin: on simultaneous I and D requests, the source not granted last wins.
REQ-032 Without MEM_ARB_RR_EN, priority SHALL be fixed D-over-I; the last-grant flag SHALL not exist.

Verification
REQ-033 i_read=1, i_addr=0x0000_1000; memory responds after 5 cycles with 0xAA..AA -> pmem_read=1, pmem_addr=0x1000 held 5 cycles; i_resp pulses once with i_rdata=0xAA..AA; DONE, then IDLE.
REQ-034 d_write=1, d_addr=0x0000_2040, d_wdata=0x55..55 -> pmem_write=1, pmem_wdata=0x55..55 stable until pmem_resp; d_resp single pulse; pmem_read never 1.
REQ-035 i_read and d_read both held high from idle, three back-to-back requests:
  - with MEM_ARB_RR_EN, grant order D, I, D;
  - without it, D, D, D while d_read remains high.
REQ-036 d_read granted, then d_read dropped after 1 cycle -> transfer still completes; d_resp pulses; pmem_addr unchanged throughout.
REQ-037 rst=0 asserted 2 cycles into an I transfer, pmem_resp arriving next cycle -> no i_resp; pmem_read=0 from the cycle after the reset edge; FSM in IDLE.
REQ-038 Stray pmem_resp pulse in IDLE with no requests -> no resp outputs, FSM remains IDLE.
